// File: rtl/decoder_pkg.sv
// Shared constants, select encoding and the seven-segment font for the decoder.
package decoder_pkg;

    localparam int SW_W  = 10;
    localparam int NIB_W = 4;
    localparam int SEG_W = 7;

    localparam logic [NIB_W-1:0] DC2_NONE = 4'hF;

    typedef enum logic [1:0] {
        SEL_POP  = 2'b00,
        SEL_PRIO = 2'b01,
        SEL_XOR  = 2'b10,
        SEL_AND  = 2'b11
    } sel_e;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 0 first.
    localparam logic [0:15][SEG_W-1:0] SEG_FONT = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    function automatic logic [NIB_W-1:0] popCount(input logic [SW_W-1:0] sw);
        logic [NIB_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < SW_W; i++) begin
            cnt = cnt + {{(NIB_W-1){1'b0}}, sw[i]};
        end
        return cnt;
    endfunction

    function automatic logic [NIB_W-1:0] msbIndex(input logic [SW_W-1:0] sw);
        logic [NIB_W-1:0] idx;
        idx = DC2_NONE;
        for (int i = 0; i < SW_W; i++) begin
            if (sw[i]) begin
                idx = i[NIB_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/decoder_hex_to_seg.sv
// Combinational nibble-to-segment lookup; DECODER_HEX_ACTIVE_HIGH_EN selects 1 = segment lit.
module hex_to_seg
    import decoder_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    logic [SEG_W-1:0] segLow;

    always_comb begin
        segLow = SEG_BLANK;
        case (nibble_i)
            4'h0:    segLow = SEG_FONT[0];
            4'h1:    segLow = SEG_FONT[1];
            4'h2:    segLow = SEG_FONT[2];
            4'h3:    segLow = SEG_FONT[3];
            4'h4:    segLow = SEG_FONT[4];
            4'h5:    segLow = SEG_FONT[5];
            4'h6:    segLow = SEG_FONT[6];
            4'h7:    segLow = SEG_FONT[7];
            4'h8:    segLow = SEG_FONT[8];
            4'h9:    segLow = SEG_FONT[9];
            4'hA:    segLow = SEG_FONT[10];
            4'hB:    segLow = SEG_FONT[11];
            4'hC:    segLow = SEG_FONT[12];
            4'hD:    segLow = SEG_FONT[13];
            4'hE:    segLow = SEG_FONT[14];
            default: segLow = SEG_FONT[15];
        endcase
    end

`ifdef DECODER_HEX_ACTIVE_HIGH_EN
    assign seg_o = ~segLow;
`else
    assign seg_o = segLow;
`endif

endmodule

// File: rtl/decoder.sv
// Registered switch decoder: popcount, MSB index, XOR/AND nibbles, muxed onto HEX0.
// Display polarity follows DECODER_HEX_ACTIVE_HIGH_EN (undefined = active-low).
module decoder
    import decoder_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [SW_W-1:0]  sw_i,
    output logic [SEG_W-1:0] hex_o,
    output logic [NIB_W-1:0] dc1_o,
    output logic [NIB_W-1:0] dc2_o,
    output logic [NIB_W-1:0] f_o
);

`ifdef DECODER_HEX_ACTIVE_HIGH_EN
    localparam logic [SEG_W-1:0] HEX_RST = ~SEG_FONT[0];
`else
    localparam logic [SEG_W-1:0] HEX_RST = SEG_FONT[0];
`endif

    logic [NIB_W-1:0] dc1_d, dc2_d, f_d;
    logic [NIB_W-1:0] dc1_q, dc2_q, f_q;
    logic [SEG_W-1:0] hex_d, hex_q;
    sel_e             sel;

    assign sel = sel_e'(sw_i[SW_W-1 -: 2]);

    // f and hex derive from this cycle's comb results so all outputs agree.
    always_comb begin
        dc1_d = popCount(sw_i);
        dc2_d = msbIndex(sw_i);
        f_d   = '0;
        case (sel)
            SEL_POP:  f_d = dc1_d;
            SEL_PRIO: f_d = dc2_d;
            SEL_XOR:  f_d = sw_i[3:0] ^ sw_i[7:4];
            SEL_AND:  f_d = sw_i[3:0] & sw_i[7:4];
            default:  f_d = '0;
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .nibble_i (f_d),
        .seg_o    (hex_d)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dc1_q <= '0;
            dc2_q <= '0;
            f_q   <= '0;
            hex_q <= HEX_RST;
        end else begin
            dc1_q <= dc1_d;
            dc2_q <= dc2_d;
            f_q   <= f_d;
            hex_q <= hex_d;
        end
    end

    assign dc1_o = dc1_q;
    assign dc2_o = dc2_q;
    assign f_o   = f_q;
    assign hex_o = hex_q;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder; honours DECODER_HEX_ACTIVE_HIGH_EN for hex polarity.
module tb_decoder;

    logic       clk_i;
    logic       rstn_i;
    logic [9:0] sw_i;
    logic [6:0] hex_o;
    logic [3:0] dc1_o, dc2_o, f_o;

    int nChecks;
    int nFails;

    typedef struct packed {
        logic [9:0] sw;
        logic [3:0] dc1;
        logic [3:0] dc2;
        logic [3:0] f;
        logic [6:0] hexLow;
    } vec_t;

    localparam int NVEC = 11;

    vec_t vecs [0:NVEC-1] = '{
        '{10'h3FF, 4'hA, 4'h9, 4'hF, 7'b0001110},
        '{10'h1FF, 4'h9, 4'h8, 4'h8, 7'b0000000},
        '{10'h2FF, 4'h9, 4'h9, 4'h0, 7'b1000000},
        '{10'h0FA, 4'h6, 4'h7, 4'h6, 7'b0000010},
        '{10'h000, 4'h0, 4'hF, 4'h0, 7'b1000000},
        '{10'h100, 4'h1, 4'h8, 4'h8, 7'b0000000},
        '{10'h3A6, 4'h6, 4'h9, 4'h2, 7'b0100100},
        '{10'h235, 4'h5, 4'h9, 4'h6, 7'b0000010},
        '{10'h001, 4'h1, 4'h0, 4'h1, 7'b1111001},
        '{10'h20A, 4'h3, 4'h9, 4'hA, 7'b0001000},
        '{10'h3FD, 4'h9, 4'h9, 4'hD, 7'b0100001}
    };

    decoder dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .sw_i   (sw_i),
        .hex_o  (hex_o),
        .dc1_o  (dc1_o),
        .dc2_o  (dc2_o),
        .f_o    (f_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Converts a hand-written active-low pattern to the polarity of this build.
    function automatic logic [6:0] expHex(input logic [6:0] low);
`ifdef DECODER_HEX_ACTIVE_HIGH_EN
        return ~low;
`else
        return low;
`endif
    endfunction

    task automatic test_reset();
        rstn_i = 1'b0;
        sw_i   = 10'h3FF;
        repeat (3) @(posedge clk_i);
        #1;
        nChecks += 4;
        if (dc1_o !== 4'h0) begin nFails++; $display("[TB] FAIL reset_dc1 got %h want 0", dc1_o); end
        if (dc2_o !== 4'h0) begin nFails++; $display("[TB] FAIL reset_dc2 got %h want 0", dc2_o); end
        if (f_o !== 4'h0)   begin nFails++; $display("[TB] FAIL reset_f got %h want 0", f_o); end
        if (hex_o !== expHex(7'b1000000)) begin
            nFails++; $display("[TB] FAIL reset_hex got %b want %b", hex_o, expHex(7'b1000000));
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        nChecks++;
        if (dc1_o !== 4'h0) begin nFails++; $display("[TB] FAIL release_no_capture_dc1 got %h want 0", dc1_o); end
        @(posedge clk_i);
        #1;
        nChecks++;
        if (dc1_o !== 4'hA) begin nFails++; $display("[TB] FAIL first_capture_dc1 got %h want a", dc1_o); end
    endtask

    task automatic test_vectors();
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_i);
            sw_i = vecs[i].sw;
            @(posedge clk_i);
            #1;
            nChecks += 4;
            if (dc1_o !== vecs[i].dc1) begin
                nFails++; $display("[TB] FAIL vec%0d_dc1 sw=%h got %h want %h", i, vecs[i].sw, dc1_o, vecs[i].dc1);
            end
            if (dc2_o !== vecs[i].dc2) begin
                nFails++; $display("[TB] FAIL vec%0d_dc2 sw=%h got %h want %h", i, vecs[i].sw, dc2_o, vecs[i].dc2);
            end
            if (f_o !== vecs[i].f) begin
                nFails++; $display("[TB] FAIL vec%0d_f sw=%h got %h want %h", i, vecs[i].sw, f_o, vecs[i].f);
            end
            if (hex_o !== expHex(vecs[i].hexLow)) begin
                nFails++; $display("[TB] FAIL vec%0d_hex sw=%h got %b want %b", i, vecs[i].sw, hex_o, expHex(vecs[i].hexLow));
            end
        end
    endtask

    // New input right after each edge: outputs must hold until the next edge.
    task automatic test_back_to_back();
        @(negedge clk_i);
        sw_i = vecs[0].sw;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NVEC; i++) begin
            sw_i = vecs[(i + 1) % NVEC].sw;
            #2;
            nChecks += 3;
            if (dc1_o !== vecs[i].dc1) begin
                nFails++; $display("[TB] FAIL b2b%0d_dc1 got %h want %h", i, dc1_o, vecs[i].dc1);
            end
            if (dc2_o !== vecs[i].dc2) begin
                nFails++; $display("[TB] FAIL b2b%0d_dc2 got %h want %h", i, dc2_o, vecs[i].dc2);
            end
            if (f_o !== vecs[i].f) begin
                nFails++; $display("[TB] FAIL b2b%0d_f got %h want %h", i, f_o, vecs[i].f);
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk_i);
        sw_i = 10'h3FF;
        @(posedge clk_i);
        #3;
        rstn_i = 1'b0;
        #1;
        nChecks += 4;
        if (dc1_o !== 4'h0) begin nFails++; $display("[TB] FAIL async_reset_dc1 got %h want 0", dc1_o); end
        if (dc2_o !== 4'h0) begin nFails++; $display("[TB] FAIL async_reset_dc2 got %h want 0", dc2_o); end
        if (f_o !== 4'h0)   begin nFails++; $display("[TB] FAIL async_reset_f got %h want 0", f_o); end
        if (hex_o !== expHex(7'b1000000)) begin
            nFails++; $display("[TB] FAIL async_reset_hex got %b want %b", hex_o, expHex(7'b1000000));
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        nChecks++;
        if (hex_o !== expHex(7'b0001110)) begin
            nFails++; $display("[TB] FAIL after_reset_hex got %b want %b", hex_o, expHex(7'b0001110));
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        rstn_i  = 1'b0;
        sw_i    = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

endmodule
